// File: rtl/div_pkg.sv
// Shared encodings and bus widths for the multi-cycle divider.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Number of restoring steps, one quotient bit per step.
  localparam logic [5:0] DivSteps = 6'd32;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
// Result is {remainder, quotient}, held while ready_o is high.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o
);

  div_state_e state, state_d;

  logic [5:0]          cnt;
  logic [64:0]         wr;
  logic [RegBus-1:0]   divisor_mag;
  logic                dividend_neg;
  logic                divisor_neg;
  logic                signed_op;

  logic [RegBus-1:0]       op1_mag;
  logic [RegBus-1:0]       op2_mag;
  logic [RegBus:0]         diff;
  logic [RegBus-1:0]       quotient;
  logic [RegBus-1:0]       remainder;
  logic [DoubleRegBus-1:0] result_d;
  logic                    ready_d;

  // Operand magnitudes, captured only on the DivFree -> DivOn transition.
  assign op1_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + RegBus'(1)) : opdata1_i;
  assign op2_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + RegBus'(1)) : opdata2_i;

  // Trial subtraction; bit 32 set means the partial remainder is too small.
  assign diff = {1'b0, wr[63:32]} - {1'b0, divisor_mag};

  assign quotient  = (signed_op && (dividend_neg ^ divisor_neg)) ? (~wr[31:0] + RegBus'(1)) : wr[31:0];
  assign remainder = (signed_op && dividend_neg) ? (~wr[64:33] + RegBus'(1)) : wr[64:33];

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= DivFree;
    else     state <= state_d;
  end

  // NOTE: each combinational block assigns a default to every output first,
  // so no path through the case leaves a variable unassigned (no latches).
  always_comb begin
    state_d = state;
    case (state)
      DivFree: begin
        if (start_i == DivStart && !annul_i)
          state_d = (opdata2_i == ZeroWord) ? DivByZero : DivOn;
      end
      DivByZero: state_d = annul_i ? DivFree : DivEnd;
      DivOn: begin
        if (annul_i)              state_d = DivFree;
        else if (cnt == DivSteps) state_d = DivEnd;
      end
      DivEnd: begin
        if (start_i == DivStop) state_d = DivFree;
      end
      default: state_d = DivFree;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    result_d = result_o;
    ready_d  = ready_o;
    case (state)
      DivFree: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
      DivByZero: begin
        result_d = '0;
        ready_d  = annul_i ? DivResultNotReady : DivResultReady;
      end
      DivOn: begin
        if (annul_i) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end else if (cnt == DivSteps) begin
          result_d = {remainder, quotient};
          ready_d  = DivResultReady;
        end
      end
      DivEnd: begin
        if (start_i == DivStop) begin
          result_d = '0;
          ready_d  = DivResultNotReady;
        end
      end
      default: begin
        result_d = '0;
        ready_d  = DivResultNotReady;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      wr           <= '0;
      divisor_mag  <= '0;
      dividend_neg <= 1'b0;
      divisor_neg  <= 1'b0;
      signed_op    <= 1'b0;
      result_o     <= '0;
      ready_o      <= DivResultNotReady;
    end else begin
      result_o <= result_d;
      ready_o  <= ready_d;
      case (state)
        DivFree: begin
          cnt <= '0;
          if (state_d == DivOn) begin
            wr           <= {32'b0, op1_mag, 1'b0};
            divisor_mag  <= op2_mag;
            dividend_neg <= opdata1_i[31];
            divisor_neg  <= opdata2_i[31];
            signed_op    <= signed_div_i;
          end
        end
        DivOn: begin
          if (annul_i) begin
            cnt <= '0;
          end else if (cnt != DivSteps) begin
            if (diff[32]) wr <= {wr[63:0], 1'b0};
            else          wr <= {diff[31:0], wr[31:0], 1'b1};
            cnt <= cnt + 6'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div.sv
// Self-checking bench for div: randomized and directed requests, expected
// results from plain integer division, compared by an independent monitor.
module tb_div;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  div dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [63:0] res;
    int          edge_n;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Truncating integer division: quotient rounds toward zero, remainder
  // takes the dividend's sign. Divide-by-zero yields all zeros.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input bit sgn);
    longint sa, sb, q, r;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: on every rising ready_o, pop and compare result and latency;
  // while ready_o stays high, the result must stay at the expected value.
  logic        prev_ready = 1'b0;
  logic [63:0] held       = 64'h0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_ready = 1'b0;
    end else begin
      if (ready_o && !prev_ready) begin
        if (sb_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_ready: ready_o=1 with no request outstanding, result %h", result_o);
          held = 64'h0;
        end else begin
          e = sb_q.pop_front();
          check("result", result_o, e.res);
          check("latency", 64'(edge_cnt), 64'(e.edge_n));
          held = e.res;
        end
      end else if (ready_o) begin
        check("hold", result_o, held);
      end
      prev_ready = ready_o;
    end
  end

  task automatic drive_req(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    signed_div_i = sgn;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
  endtask

  // Issue one request at a falling edge, wait for ready, hold start for
  // `hold` extra cycles (with stray annul pulses), then release.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b, input int hold);
    exp_t e;
    int   n;
    e.res    = ref_div(a, b, sgn);
    e.edge_n = edge_cnt + ((b == 32'h0) ? 2 : 34);
    sb_q.push_back(e);
    drive_req(sgn, a, b);
    @(negedge clk);
    opdata1_i    = $urandom;
    opdata2_i    = $urandom;
    signed_div_i = 1'($urandom_range(0, 1));
    n = 0;
    while (!ready_o && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      checks++;
      failures++;
      $display("FAIL ready_timeout: ready_o=0 after %0d cycles, required 1", n + 1);
    end
    repeat (hold) begin
      annul_i = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    annul_i = 1'b0;
    start_i = 1'b0;
    @(negedge clk);
    check("drop_ready", 64'(ready_o), 64'h0);
    check("drop_result", result_o, 64'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b;
    bit          sgn;

    rst          = 1'b1;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    signed_div_i = 1'b0;
    opdata1_i    = 32'h0;
    opdata2_i    = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_ready", 64'(ready_o), 64'h0);
    check("reset_result", result_o, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    run_op(1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 1);
    run_op(1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 0);
    run_op(1'b0, 32'h0000_1234, 32'h0000_0000, 5);
    run_op(1'b1, 32'h8000_0000, 32'h0000_0000, 5);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 2);

    // Annul at cnt=10, then a fresh 100/7 request.
    drive_req(1'b0, 32'd500, 32'd3);
    repeat (11) @(negedge clk);
    annul_i = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    annul_i = 1'b0;
    check("annul_ready", 64'(ready_o), 64'h0);
    check("annul_result", result_o, 64'h0);
    run_op(1'b0, 32'd100, 32'd7, 1);

    // Reset at cnt=20; the next request must see full latency from DivFree.
    drive_req(1'b1, $urandom, 32'd12345);
    repeat (21) @(negedge clk);
    rst     = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(ready_o), 64'h0);
    check("midrst_result", result_o, 64'h0);
    rst = 1'b0;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);

    // Randomized requests.
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 4))
        0:       b = 32'h0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        3:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      run_op(sgn, a, b, $urandom_range(0, 3));
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
